// File: rtl/tilexy_inject_arb.sv
// tilexy_inject_arb: round-robin injection arbiter sharing one X/Y mesh FIFO
// write port between NREQ requesters, with wrt_stall backpressure, a credit
// budget for outstanding injections and atomic multi-beat bursts.
// Optional build macro TILEXY_INJECT_ARB_AGE_EN adds per-requester wait
// counters with starvation priority and a starve_flag output.
module tilexy_inject_arb #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned DW      = 528,
  parameter int unsigned AW      = 37,
  parameter int unsigned SW      = 12,
  parameter int unsigned CREDITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*SW-1:0] req_size,
  output logic [NREQ-1:0]    req_ready,
  input  logic               wrt_stall,
  input  logic               credit_ret,
  output logic               in_en,
  output logic [DW-1:0]      in_datum,
  output logic [AW-1:0]      in_addr,
  output logic [SW-1:0]      insize,
  output logic [2:0]         grant_id,
  output logic [3:0]         credits
`ifdef TILEXY_INJECT_ARB_AGE_EN
  ,
  output logic               starve_flag
`endif
);

  localparam int unsigned   IW       = 3;
  localparam int unsigned   CW       = 4;
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] credits_q, credits_d;
  logic          in_en_q, in_en_d;
  logic [DW-1:0] datum_q, datum_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SW-1:0] size_q, size_d;
  logic [IW-1:0] gid_q, gid_d;

  logic          sel_valid;
  logic          sel_last;
  logic [IW-1:0] sel_idx;
  logic [DW-1:0] sel_data;
  logic [AW-1:0] sel_addr;
  logic [SW-1:0] sel_size;
  logic          out_free;
  logic          can_take;
  logic          take;
  int unsigned   rr_pos;

`ifdef TILEXY_INJECT_ARB_AGE_EN
  localparam int unsigned AGEW = 4;
  logic [AGEW-1:0] age_q [NREQ];
  logic [AGEW-1:0] age_d [NREQ];
  logic            starve_q, starve_d;
`endif

  // Output slot can accept a new beat when empty or drained this cycle.
  assign out_free = !in_en_q || !wrt_stall;
  // A returning credit this cycle covers a take at zero credits.
  assign can_take = (credits_q != '0) || credit_ret;
  assign take     = sel_valid && out_free && can_take;

  // Requester selection: locked owner, else starving requester, else round-robin.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    rr_pos    = 0;
    if (state_q == LOCK) begin
      sel_idx = owner_q;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (owner_q == IW'(i)) sel_valid = req_valid[i];
      end
    end else begin
`ifdef TILEXY_INJECT_ARB_AGE_EN
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!sel_valid && req_valid[i] && (age_q[i] == '1)) begin
          sel_valid = 1'b1;
          sel_idx   = IW'(i);
        end
      end
`endif
      for (int unsigned k = 0; k < NREQ; k++) begin
        rr_pos = (32'(rr_q) + k) % NREQ;
        for (int unsigned j = 0; j < NREQ; j++) begin
          if (!sel_valid && (rr_pos == j) && req_valid[j]) begin
            sel_valid = 1'b1;
            sel_idx   = IW'(j);
          end
        end
      end
    end
  end

  // Payload mux and one-hot ready for the selected requester.
  always_comb begin
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_addr  = '0;
    sel_size  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_last     = req_last[i];
        sel_data     = req_data[i*DW +: DW];
        sel_addr     = req_addr[i*AW +: AW];
        sel_size     = req_size[i*SW +: SW];
        req_ready[i] = take;
      end
    end
  end

  // Burst-lock FSM next state and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    if (take) begin
      if (sel_last) begin
        state_d = IDLE;
        rr_d    = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + IW'(1);
      end else begin
        state_d = LOCK;
        owner_d = sel_idx;
      end
    end
  end

  // Output register and credit counter next values.
  always_comb begin
    in_en_d   = in_en_q;
    datum_d   = datum_q;
    addr_d    = addr_q;
    size_d    = size_q;
    gid_d     = gid_q;
    credits_d = credits_q;
    if (take) begin
      in_en_d = 1'b1;
      datum_d = sel_data;
      addr_d  = sel_addr;
      size_d  = sel_size;
      gid_d   = sel_idx;
    end else if (in_en_q && !wrt_stall) begin
      in_en_d = 1'b0;
    end
    if (take && !credit_ret) begin
      credits_d = credits_q - CW'(1);
    end else if (!take && credit_ret && (credits_q != CRED_MAX)) begin
      credits_d = credits_q + CW'(1);
    end
  end

  // State, pointer, credit and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      credits_q <= CRED_MAX;
      in_en_q   <= 1'b0;
      datum_q   <= '0;
      addr_q    <= '0;
      size_q    <= '0;
      gid_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      credits_q <= credits_d;
      in_en_q   <= in_en_d;
      datum_q   <= datum_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      gid_q     <= gid_d;
    end
  end

`ifdef TILEXY_INJECT_ARB_AGE_EN
  // Wait counters: count blocked cycles, saturate, clear on grant.
  always_comb begin
    starve_d = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      age_d[i] = age_q[i];
      if (req_ready[i]) begin
        age_d[i] = '0;
      end else if (req_valid[i] && (age_q[i] != '1)) begin
        age_d[i] = age_q[i] + AGEW'(1);
        if (age_d[i] == '1) starve_d = 1'b1;
      end
    end
  end

  // Wait counter and starvation pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREQ; i++) age_q[i] <= '0;
      starve_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) age_q[i] <= age_d[i];
      starve_q <= starve_d;
    end
  end

  assign starve_flag = starve_q;
`endif

  assign in_en    = in_en_q;
  assign in_datum = datum_q;
  assign in_addr  = addr_q;
  assign insize   = size_q;
  assign grant_id = gid_q;
  assign credits  = credits_q;

endmodule

// File: tb/tb_tilexy_inject_arb.sv
// Scoreboard bench for tilexy_inject_arb: directed tests push expected beats,
// a negedge monitor pops and compares every beat the FIFO consumes.
module tb_tilexy_inject_arb;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 528;
  localparam int unsigned AW   = 37;
  localparam int unsigned SW   = 12;

  typedef struct {
    logic [2:0]    g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid, req_last, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*SW-1:0] req_size;
  logic               wrt_stall, credit_ret;
  logic               in_en;
  logic [DW-1:0]      in_datum;
  logic [AW-1:0]      in_addr;
  logic [SW-1:0]      insize;
  logic [2:0]         grant_id;
  logic [3:0]         credits;
`ifdef TILEXY_INJECT_ARB_AGE_EN
  logic               starve_flag;
  int                 starves;
`endif

  int    left [NREQ];
  int    blen [NREQ];
  int    pos  [NREQ];
  int    seq  [NREQ];
  beat_t exq  [$];
  int    total = 0;
  int    bad   = 0;

  tilexy_inject_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_ready  (req_ready),
    .wrt_stall  (wrt_stall),
    .credit_ret (credit_ret),
    .in_en      (in_en),
    .in_datum   (in_datum),
    .in_addr    (in_addr),
    .insize     (insize),
    .grant_id   (grant_id),
    .credits    (credits)
`ifdef TILEXY_INJECT_ARB_AGE_EN
    ,
    .starve_flag(starve_flag)
`endif
  );

  initial forever #5 clk = ~clk;

  function automatic logic [AW-1:0] mk_addr(input int i, input int s);
    return 37'h1_0000_0000 + AW'(i << 6) + AW'(s << 12);
  endfunction

  function automatic logic [DW-1:0] mk_data(input int i, input int s);
    logic [15:0] p;
    p = {8'(i), 8'(s)};
    return {33{p}};
  endfunction

  function automatic logic [SW-1:0] mk_size(input int i, input int s);
    return SW'(i * 16 + s);
  endfunction

  task automatic push(input int i, input int s);
    beat_t b;
    b.g = 3'(i);
    b.a = mk_addr(i, s);
    b.d = mk_data(i, s);
    b.s = mk_size(i, s);
    exq.push_back(b);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive requester buses from the source model, then let them settle.
  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]             = (left[i] > 0);
      req_last[i]              = (pos[i] == blen[i] - 1);
      req_data[i*DW +: DW]     = mk_data(i, seq[i]);
      req_addr[i*AW +: AW]     = mk_addr(i, seq[i]);
      req_size[i*SW +: SW]     = mk_size(i, seq[i]);
    end
    #1;
  endtask

  // One clock: requesters whose beat was accepted advance to their next beat.
  task automatic step();
    logic [NREQ-1:0] r;
    @(negedge clk);
    r = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        left[i]--;
        pos[i] = (pos[i] + 1) % blen[i];
        seq[i]++;
      end
    end
    apply();
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    wrt_stall  = 1'b0;
    credit_ret = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = 0;
      blen[i] = 1;
      pos[i]  = 0;
      seq[i]  = 0;
    end
    apply();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pos[i] = 0;
      seq[i] = 0;
    end
    exq.delete();
    apply();
  endtask

  // Scoreboard monitor: every consumed beat must match the next expected one.
  always @(negedge clk) begin
    if (!rst && in_en && !wrt_stall) begin
      total++;
      if (exq.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got grant=%0d addr=%0h expected no beat", grant_id, in_addr);
      end else begin
        beat_t e;
        e = exq.pop_front();
        if (grant_id !== e.g || in_addr !== e.a || insize !== e.s || in_datum !== e.d) begin
          bad++;
          $display("FAIL beat: got grant=%0d addr=%0h size=%0h data_ok=%0d expected grant=%0d addr=%0h size=%0h",
                   grant_id, in_addr, insize, (in_datum === e.d), e.g, e.a, e.s);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    req_addr  = '0;
    req_size  = '0;
    do_reset();

    // Reset state
    chk("rst_in_en", in_en, 0);
    chk("rst_credits", credits, 8);
    chk("rst_grant", grant_id, 0);
    chk("rst_ready", req_ready, 0);

    // Single beat from requester 1
    left[1] = 1;
    push(1, 0);
    apply();
    chk("single_ready", req_ready, 3'b010);
    step();
    chk("single_in_en", in_en, 1);
    chk("single_addr", in_addr, 64'h1_0000_0040);
    chk("single_grant", grant_id, 1);
    chk("single_credits", credits, 7);
    step();
    chk("single_idle", in_en, 0);
    chk("single_drain", exq.size(), 0);

    // Fairness: all valid, credit returned every cycle
    do_reset();
    for (int i = 0; i < NREQ; i++) left[i] = 6;
    credit_ret = 1'b1;
    for (int s = 0; s < 6; s++) begin
      push(0, s);
      push(1, s);
      push(2, s);
    end
    apply();
    chk("fair_ready0", req_ready, 3'b001);
    step();
    chk("fair_ready1", req_ready, 3'b010);
    chk("fair_credits0", credits, 8);
    repeat (20) step();
    chk("fair_credits", credits, 8);
    chk("fair_drain", exq.size(), 0);
    credit_ret = 1'b0;

    // Stall holds the output beat
    do_reset();
    left[0] = 3;
    for (int s = 0; s < 3; s++) push(0, s);
    apply();
    step();
    wrt_stall = 1'b1;
    apply();
    for (int k = 0; k < 4; k++) begin
      chk("stall_ready", req_ready, 0);
      chk("stall_addr", in_addr, mk_addr(0, 0));
      chk("stall_in_en", in_en, 1);
      step();
    end
    wrt_stall = 1'b0;
    apply();
    chk("stall_release_ready", req_ready, 3'b001);
    step();
    chk("stall_next_addr", in_addr, mk_addr(0, 1));
    repeat (3) step();
    chk("stall_drain", exq.size(), 0);
    chk("stall_credits", credits, 5);

    // Credit exhaustion
    do_reset();
    left[0] = 10;
    for (int s = 0; s < 8; s++) push(0, s);
    apply();
    repeat (12) step();
    chk("cred_zero", credits, 0);
    chk("cred_ready", req_ready, 0);
    chk("cred_takes", seq[0], 8);
    chk("cred_drain", exq.size(), 0);
    push(0, 8);
    credit_ret = 1'b1;
    apply();
    chk("cred_ret_ready", req_ready, 3'b001);
    step();
    credit_ret = 1'b0;
    apply();
    chk("cred_ret_credits", credits, 0);
    chk("cred_ret_ready_off", req_ready, 0);
    repeat (3) step();
    chk("cred_ret_takes", seq[0], 9);
    chk("cred_ret_drain", exq.size(), 0);

    // Burst lock: requester 2 burst while requester 0 waits
    do_reset();
    left[1] = 1;
    push(1, 0);
    apply();
    step();
    left[2] = 3;
    blen[2] = 3;
    left[0] = 1;
    push(2, 0);
    push(2, 1);
    push(2, 2);
    push(0, 0);
    apply();
    chk("burst_ready_b0", req_ready, 3'b100);
    step();
    chk("burst_ready_b1", req_ready, 3'b100);
    step();
    chk("burst_ready_b2", req_ready, 3'b100);
    step();
    chk("burst_ready_r0", req_ready, 3'b001);
    repeat (3) step();
    chk("burst_drain", exq.size(), 0);

    // Reset in the middle of a locked burst
    do_reset();
    left[2] = 4;
    blen[2] = 4;
    apply();
    chk("rstb_ready", req_ready, 3'b100);
    step();
    chk("rstb_in_en", in_en, 1);
    rst     = 1'b1;
    left[0] = 1;
    left[2] = 0;
    apply();
    step();
    chk("rstb_in_en_after", in_en, 0);
    chk("rstb_credits", credits, 8);
    rst = 1'b0;
    push(0, 0);
    apply();
    chk("rstb_r0_first", req_ready, 3'b001);
    repeat (3) step();
    chk("rstb_drain", exq.size(), 0);

`ifdef TILEXY_INJECT_ARB_AGE_EN
    // Starved requester 1 beats round-robin after a long burst
    do_reset();
    left[1] = 1;
    push(1, 0);
    apply();
    step();
    left[2]    = 17;
    blen[2]    = 17;
    left[1]    = 1;
    credit_ret = 1'b1;
    for (int s = 0; s < 17; s++) push(2, s);
    push(1, 1);
    push(0, 0);
    apply();
    starves = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 10) begin
        left[0] = 1;
        apply();
      end
      step();
      if (starve_flag) starves++;
    end
    chk("age_starve_pulses", starves, 1);
    chk("age_drain", exq.size(), 0);
    credit_ret = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
